bb_req_arbiter: RTL

Round-robin arbiter that shares one REQ/ACK pulse-handshake datapath between NREQ requesters. It issues single-cycle downstream requests, tracks outstanding requests in issue order, and routes each returning ACK pulse and its DATA sample back to the requester that owns it. It sits between the requester logic and the REQ/ACK/DATA port of the downstream block.

---
 rtl/bb_req_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bb_req_arbiter.sv
// Round-robin arbiter sharing one REQ/ACK pulse-handshake port between NREQ requesters.
// An in-order ID FIFO routes each downstream ACK and its data back to the owning requester.
module bb_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned DW      = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_stall,
    input  logic [NREQ-1:0]              i_req,
    output logic [NREQ-1:0]              o_ack,
    output logic [DW-1:0]                o_data,
    output logic                         o_dn_req,
    input  logic                         i_dn_ack,
    input  logic [DW-1:0]                i_dn_data,
    output logic [$clog2(MAX_OUT+1)-1:0] o_outst,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [OW-1:0] OutMax  = OW'(MAX_OUT);
    localparam logic [IW:0]   NreqW   = (IW + 1)'(NREQ);
    localparam logic [IW-1:0] IdLast  = IW'(NREQ - 1);
    localparam logic [PW-1:0] PtrLast = PW'(MAX_OUT - 1);

    typedef enum logic [1:0] {StIdle, StActive, StFull, StFault} state_e;

    state_e          r_state, w_state_d;
    logic [OW-1:0]   r_outst, w_outst_d;
    logic [NREQ-1:0] r_pending, w_pending_d;
    logic [NREQ-1:0] r_ack, w_ack_d;
    logic [NREQ-1:0] w_elig;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_win;
    logic [IW:0]     w_sum;
    logic            w_found;
    logic            w_issue;
    logic            w_pop;
    logic            w_spurious;
    logic [DW-1:0]   r_data;
    logic            r_dn_req;
    logic            r_err;
    logic [IW-1:0]   r_fifo [MAX_OUT];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [IW-1:0]   w_head;

    // The ACK_O mask stops a requester being re-granted while it is still dropping REQ_I.
    assign w_elig = i_req & ~r_pending & ~r_ack;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            w_sum = {1'b0, r_rr_ptr} + (IW + 1)'(j);
            if (w_sum >= NreqW) begin
                w_sum = w_sum - NreqW;
            end
            if (!w_found && w_elig[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IW-1:0];
            end
        end
    end

    assign w_issue    = w_found & ~i_stall & (r_outst < OutMax) & (r_state != StFault);
    assign w_pop      = i_dn_ack & (r_outst != '0);
    assign w_spurious = i_dn_ack & (r_outst == '0);
    assign w_head     = r_fifo[r_rd_ptr];

    always_comb begin
        w_outst_d   = r_outst;
        w_pending_d = r_pending;
        w_ack_d     = '0;
        if (w_issue && !w_pop) begin
            w_outst_d = r_outst + OW'(1);
        end else if (!w_issue && w_pop) begin
            w_outst_d = r_outst - OW'(1);
        end
        if (w_pop) begin
            w_pending_d[w_head] = 1'b0;
            w_ack_d[w_head]     = 1'b1;
        end
        if (w_issue) begin
            w_pending_d[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (r_state == StFault || w_spurious) begin
            w_state_d = StFault;
        end else if (w_outst_d == '0) begin
            w_state_d = StIdle;
        end else if (w_outst_d == OutMax) begin
            w_state_d = StFull;
        end else begin
            w_state_d = StActive;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_outst   <= '0;
            r_pending <= '0;
            r_ack     <= '0;
            r_data    <= '0;
            r_dn_req  <= 1'b0;
            r_err     <= 1'b0;
            r_rr_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_state   <= w_state_d;
            r_outst   <= w_outst_d;
            r_pending <= w_pending_d;
            r_ack     <= w_ack_d;
            r_dn_req  <= w_issue;
            if (w_spurious) begin
                r_err <= 1'b1;
            end
            if (w_pop) begin
                r_data   <= i_dn_data;
                r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_issue) begin
                r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PW'(1);
                r_rr_ptr <= (w_win == IdLast) ? '0 : w_win + IW'(1);
            end
        end
    end

    // Entries are only read between push and pop, so the storage needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_fifo[r_wr_ptr] <= w_win;
        end
    end

    assign o_ack    = r_ack;
    assign o_data   = r_data;
    assign o_dn_req = r_dn_req;
    assign o_outst  = r_outst;
    assign o_err    = r_err;
    assign o_busy   = (r_outst != '0) | r_dn_req;

endmodule
